// File: rtl/regfile_dump_32_pkg.sv
// Shared sizing and dump FSM state encoding for regfile_dump_32.
// Contents: register count, address/data widths, last index, and the dump_state_e enum.
package regfile_dump_32_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  localparam logic [ADDR_W-1:0] LAST_IDX =
    ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_DONE
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_32.sv
// Debug read-out engine: walks regfile registers 0..NUM_REGS-1 and streams (idx, data) beats.
// Ports: Clk/Rst (sync, active-high), Start/Abort, RegAddr/RegData, Out* channel, Busy, Done.
module regfile_dump_32
  import regfile_dump_32_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic              Abort,
  output logic [ADDR_W-1:0] RegAddr,
  input  logic [DATA_W-1:0] RegData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [ADDR_W-1:0] OutIdx,
  output logic [DATA_W-1:0] OutData,
  output logic              Busy,
  output logic              Done
);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] oidx_q, oidx_d;
  logic [DATA_W-1:0] odata_q, odata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    oidx_d  = oidx_q;
    odata_d = odata_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_FETCH;
          idx_d   = '0;
        end
      end
      S_FETCH: begin
        if (Abort) begin
          state_d = S_IDLE;
          idx_d   = '0;
          valid_d = 1'b0;
        end else begin
          odata_d = RegData;
          oidx_d  = idx_q;
          valid_d = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        // Abort beats a same-cycle handshake.
        if (Abort) begin
          state_d = S_IDLE;
          idx_d   = '0;
          valid_d = 1'b0;
        end else if (valid_q && OutReady) begin
          valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        valid_d = 1'b0;
      end
    endcase
    // Status flags follow the next state.
    busy_d = (state_d == S_FETCH) ||
             (state_d == S_SEND);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      oidx_q  <= '0;
      odata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      oidx_q  <= oidx_d;
      odata_q <= odata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // idx is zero whenever idle, so it doubles as the read address.
  assign RegAddr  = idx_q;
  assign OutValid = valid_q;
  assign OutIdx   = oidx_q;
  assign OutData  = odata_q;
  assign Busy     = busy_q;
  assign Done     = done_q;

endmodule

// File: tb/tb_regfile_dump_32.sv
// Directed bench for regfile_dump_32 with a combinational regfile model.
// Scenarios: reset, full dump, backpressure, Start while busy, abort, mid-dump reset.
module tb_regfile_dump_32;

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic        Abort;
  logic [4:0]  RegAddr;
  logic [31:0] RegData;
  logic        OutValid;
  logic        OutReady;
  logic [4:0]  OutIdx;
  logic [31:0] OutData;
  logic        Busy;
  logic        Done;

  logic [31:0] mem [32];
  int passed;
  int total;

  regfile_dump_32 dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Start    (Start),
    .Abort    (Abort),
    .RegAddr  (RegAddr),
    .RegData  (RegData),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .OutIdx   (OutIdx),
    .OutData  (OutData),
    .Busy     (Busy),
    .Done     (Done)
  );

  assign RegData = mem[RegAddr];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic advance_to(input int k, output int beats, output bit hit);
    beats = 0;
    hit = 1'b0;
    OutReady = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (OutValid && (int'(OutIdx) == k)) begin
        hit = 1'b1;
        break;
      end
      if (OutValid) beats++;
      step();
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    Start = 1'b1;
    Abort = 1'b0;
    OutReady = 1'b1;
    step();
    step();
    total++;
    if ({OutValid, Busy, Done, RegAddr, OutIdx, OutData} !== '0)
      $display("FAIL reset_outs got v=%b b=%b d=%b a=%0d i=%0d dat=%h exp all 0",
               OutValid, Busy, Done, RegAddr, OutIdx, OutData);
    else passed++;
    Rst = 1'b0;
    Start = 1'b0;
    step();
    total++;
    if (Busy !== 1'b0 || OutValid !== 1'b0)
      $display("FAIL reset_start_ignored got busy=%b valid=%b exp 0 0", Busy, OutValid);
    else passed++;
  endtask

  task automatic test_full_dump();
    int beats, first, done_at;
    bit idx_ok, data_ok;
    logic [31:0] g0, g6, g7;
    OutReady = 1'b1;
    Start = 1'b1;
    step();
    Start = 1'b0;
    total++;
    if (Busy !== 1'b1 || OutValid !== 1'b0)
      $display("FAIL fd_fetch got busy=%b valid=%b exp 1 0", Busy, OutValid);
    else passed++;
    beats = 0; first = -1; done_at = -1;
    idx_ok = 1'b1; data_ok = 1'b1;
    g0 = 'x; g6 = 'x; g7 = 'x;
    for (int c = 1; c <= 200; c++) begin
      step();
      if (Done) begin
        done_at = c;
        break;
      end
      if (OutValid) begin
        if (first < 0) first = c;
        if (beats < 32) begin
          if (OutIdx !== beats[4:0]) idx_ok = 1'b0;
          if (OutData !== mem[beats]) data_ok = 1'b0;
        end
        if (beats == 0) g0 = OutData;
        if (beats == 6) g6 = OutData;
        if (beats == 7) g7 = OutData;
        beats++;
      end
    end
    total++;
    if (first !== 1) $display("FAIL fd_latency got %0d exp 1", first);
    else passed++;
    total++;
    if (beats !== 32) $display("FAIL fd_beats got %0d exp 32", beats);
    else passed++;
    total++;
    if (!idx_ok || !data_ok)
      $display("FAIL fd_order got idx_ok=%0b data_ok=%0b exp 1 1", idx_ok, data_ok);
    else passed++;
    total++;
    if (g0 !== 32'd0) $display("FAIL fd_beat0 got %0d exp 0", g0);
    else passed++;
    total++;
    if (g6 !== 32'd5678) $display("FAIL fd_beat6 got %0d exp 5678", g6);
    else passed++;
    total++;
    if (g7 !== 32'd1234) $display("FAIL fd_beat7 got %0d exp 1234", g7);
    else passed++;
    // Beat 31 is valid after edge 63 and accepted on edge 64.
    total++;
    if (done_at !== 64) $display("FAIL fd_done_time got %0d exp 64", done_at);
    else passed++;
    total++;
    if (Busy !== 1'b0) $display("FAIL fd_done_busy got %b exp 0", Busy);
    else passed++;
    step();
    total++;
    if (Done !== 1'b0 || Busy !== 1'b0)
      $display("FAIL fd_done_pulse got done=%b busy=%b exp 0 0", Done, Busy);
    else passed++;
  endtask

  task automatic test_backpressure();
    int beats, stall, dones;
    bit ok, stable_ok;
    OutReady = 1'b1;
    Start = 1'b1;
    step();
    Start = 1'b0;
    beats = 0; stall = 0; dones = 0;
    ok = 1'b1; stable_ok = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (Done) begin
        dones++;
        break;
      end
      if (OutValid) begin
        if (OutIdx == 5'd3 && stall < 5) begin
          OutReady = 1'b0;
          if (OutIdx !== 5'd3 || OutData !== mem[3]) stable_ok = 1'b0;
          stall++;
        end else begin
          OutReady = 1'b1;
          if (OutIdx !== beats[4:0]) ok = 1'b0;
          beats++;
        end
      end
      step();
    end
    OutReady = 1'b1;
    total++;
    if (stall !== 5 || !stable_ok)
      $display("FAIL bp_stall got stall=%0d stable=%0b exp 5 1", stall, stable_ok);
    else passed++;
    total++;
    if (beats !== 32 || !ok)
      $display("FAIL bp_beats got %0d order_ok=%0b exp 32 1", beats, ok);
    else passed++;
    total++;
    if (dones !== 1) $display("FAIL bp_done got %0d exp 1", dones);
    else passed++;
    step();
  endtask

  task automatic test_start_busy();
    int beats, dones;
    bit ok;
    OutReady = 1'b1;
    Start = 1'b1;
    step();
    beats = 0; dones = 0; ok = 1'b1;
    for (int c = 0; c < 90; c++) begin
      // Pulse Start mid-dump and again during the Done cycle.
      Start = (OutValid && OutIdx == 5'd10) || Done;
      if (Done) dones++;
      if (OutValid) begin
        if (OutIdx !== beats[4:0]) ok = 1'b0;
        beats++;
      end
      step();
    end
    Start = 1'b0;
    total++;
    if (beats !== 32 || !ok)
      $display("FAIL sb_beats got %0d order_ok=%0b exp 32 1", beats, ok);
    else passed++;
    total++;
    if (dones !== 1) $display("FAIL sb_done got %0d exp 1", dones);
    else passed++;
    total++;
    if (Busy !== 1'b0) $display("FAIL sb_idle got busy=%b exp 0", Busy);
    else passed++;
  endtask

  task automatic test_abort();
    int beats;
    bit hit, any_done;
    Start = 1'b1;
    step();
    Start = 1'b0;
    advance_to(12, beats, hit);
    total++;
    if (!hit || beats !== 12)
      $display("FAIL ab_reach got hit=%0b beats=%0d exp 1 12", hit, beats);
    else passed++;
    Abort = 1'b1;
    OutReady = 1'b1;
    step();
    Abort = 1'b0;
    total++;
    if (OutValid !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 || RegAddr !== 5'd0)
      $display("FAIL ab_idle got v=%b b=%b d=%b a=%0d exp 0 0 0 0",
               OutValid, Busy, Done, RegAddr);
    else passed++;
    any_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (Done || OutValid) any_done = 1'b1;
    end
    total++;
    if (any_done) $display("FAIL ab_quiet got activity=1 exp 0");
    else passed++;
    Start = 1'b1;
    step();
    Start = 1'b0;
    step();
    total++;
    if (OutValid !== 1'b1 || OutIdx !== 5'd0 || OutData !== 32'd0)
      $display("FAIL ab_restart got v=%b idx=%0d dat=%0d exp 1 0 0",
               OutValid, OutIdx, OutData);
    else passed++;
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    step();
  endtask

  task automatic test_mid_reset();
    int beats;
    bit hit, any_done;
    Start = 1'b1;
    step();
    Start = 1'b0;
    advance_to(20, beats, hit);
    total++;
    if (!hit || beats !== 20)
      $display("FAIL mr_reach got hit=%0b beats=%0d exp 1 20", hit, beats);
    else passed++;
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    total++;
    if ({OutValid, Busy, Done, RegAddr, OutIdx, OutData} !== '0)
      $display("FAIL mr_idle got v=%b b=%b d=%b a=%0d i=%0d exp all 0",
               OutValid, Busy, Done, RegAddr, OutIdx);
    else passed++;
    any_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (Done || Busy) any_done = 1'b1;
    end
    total++;
    if (any_done) $display("FAIL mr_quiet got activity=1 exp 0");
    else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[0] = 32'd0;
    mem[6] = 32'd5678;
    mem[7] = 32'd1234;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_start_busy();
    test_abort();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
